// File: rtl/div_unit.sv
// Iterative 32-step restoring divider for the RISC-V M-extension DIV/DIVU/REM/REMU ops.
// Fixed latency; rd floats whenever codif does not select a divide operation.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Enable,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [11:0]     codif,
  output logic [XLEN-1:0] rd,
  output logic            Done
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;        // dividend magnitude, becomes the quotient
  logic [XLEN-1:0]   b_q, b_d;        // divisor magnitude
  logic [XLEN-1:0]   r_q, r_d;        // partial remainder
  logic [XLEN-1:0]   result_q, result_d;
  logic              rem_q, rem_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              div0_q, div0_d;
  logic              done_q, done_d;

  logic              is_oper;
  logic              is_signed;
  logic [XLEN:0]     r_shift;
  logic [XLEN:0]     r_sub;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;

  // funct7[1:0]=01, funct3=1xx, opcode=OP covers exactly DIV, DIVU, REM, REMU.
  assign is_oper   = (codif[11:10] == 2'b01) && codif[9] && (codif[6:0] == 7'b0110011);
  assign is_signed = ~codif[7];

  assign rd   = is_oper ? result_q : {XLEN{1'bz}};
  assign Done = done_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign r_shift = {r_q, a_q[XLEN-1]};
  assign r_sub   = r_shift - {1'b0, b_q};

  // Overflow (min / -1) falls out of the magnitude path; only divide-by-zero needs patching.
  assign q_fix = div0_q ? {XLEN{1'b1}} : (qneg_q ? -a_q : a_q);
  assign r_fix = rneg_q ? -r_q : r_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    result_d = result_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Enable && is_oper) state_d = StLoad;
      end
      StLoad: begin
        if (!Enable) begin
          state_d = StIdle;
        end else begin
          rem_d   = codif[8];
          a_d     = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
          b_d     = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;
          qneg_d  = is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
          rneg_d  = is_signed && rs1[XLEN-1];
          div0_d  = (rs2 == '0);
          r_d     = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (!Enable) begin
          state_d = StIdle;
        end else begin
          if (!r_sub[XLEN]) begin
            r_d = r_sub[XLEN-1:0];
            a_d = {a_q[XLEN-2:0], 1'b1};
          end else begin
            r_d = r_shift[XLEN-1:0];
            a_d = {a_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFix: begin
        if (!Enable) begin
          state_d = StIdle;
        end else begin
          result_d = rem_q ? r_fix : q_fix;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (!Enable) begin
          state_d = StIdle;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      rem_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected results, a monitor
// checks rd and latency whenever Done rises.
module tb_div_unit;

  localparam logic [11:0] OpDiv  = 12'b011000110011;
  localparam logic [11:0] OpDivu = 12'b011010110011;
  localparam logic [11:0] OpRem  = 12'b011100110011;
  localparam logic [11:0] OpRemu = 12'b011110110011;
  localparam logic [11:0] OpMul  = 12'b010000110011;
  localparam int          Lat    = 35;

  typedef struct {
    logic [31:0] rd;
    int          start;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        Enable;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [11:0] codif;
  wire  [31:0] rd;
  logic        Done;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;
  int   cyc;
  bit   done_seen;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .Enable (Enable),
    .rs1    (rs1),
    .rs2    (rs2),
    .codif  (codif),
    .rd     (rd),
    .Done   (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: one pop per rising Done.
  always @(negedge clk) begin
    if (reset && Done && !done_seen) begin
      exp_t e;
      done_seen = 1'b1;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got Done=1 with rd=%h, required no Done", rd);
      end else begin
        e = sb_q.pop_front();
        check("result", rd, e.rd);
        check("latency", cyc - e.start, Lat);
      end
    end else if (!Done) begin
      done_seen = 1'b0;
    end
  end

  // Starts an op and returns just after Done is seen, Enable still high.
  task automatic run_op(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd);
    exp_t e;
    bit   got;
    @(negedge clk);
    codif  = op;
    rs1    = a;
    rs2    = b;
    Enable = 1'b1;
    @(posedge clk);
    #1;
    e.rd    = exp_rd;
    e.start = cyc;
    sb_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (Done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got Done=0 after 60 cycles, required Done=1");
      void'(sb_q.pop_front());
    end
    #2;
  endtask

  task automatic end_op();
    Enable = 1'b0;
    @(posedge clk);
    #1;
    check("done_clears", {31'b0, Done}, 32'd0);
  endtask

  task automatic watch_no_done(input string name, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    check(name, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    done_seen = 1'b0;
    reset     = 1'b0;
    Enable    = 1'b0;
    rs1       = '0;
    rs2       = '0;
    codif     = OpDiv;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {31'b0, Done}, 32'd0);
    check("reset_rd", rd, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Unsigned quotient, then codif change in DONE shows the stored result.
    run_op(OpDivu, 32'd100, 32'd7, 32'h0000000E);
    codif = OpRemu;
    #1;
    check("rd_after_codif_switch", rd, 32'h0000000E);
    end_op();

    run_op(OpRemu, 32'd100, 32'd7, 32'd2);                  end_op();
    run_op(OpDiv,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);      end_op();
    run_op(OpRem,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);      end_op();
    run_op(OpDiv,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);      end_op();
    run_op(OpRem,  32'd7, 32'hFFFFFFFE, 32'd1);             end_op();
    run_op(OpDiv,  32'h12345678, 32'd0, 32'hFFFFFFFF);      end_op();
    run_op(OpRemu, 32'h12345678, 32'd0, 32'h12345678);      end_op();
    run_op(OpDiv,  32'hFFFFFFF8, 32'd0, 32'hFFFFFFFF);      end_op();
    run_op(OpRem,  32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8);      end_op();
    run_op(OpDiv,  32'h80000000, 32'hFFFFFFFF, 32'h80000000); end_op();
    run_op(OpRem,  32'h80000000, 32'hFFFFFFFF, 32'd0);      end_op();
    run_op(OpDivu, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);      end_op();
    run_op(OpRemu, 32'hFFFFFFFF, 32'h10, 32'h0000000F);     end_op();
    run_op(OpDivu, 32'h80000000, 32'hFFFFFFFF, 32'd0);      end_op();

    // Operand changes during the op must not disturb it.
    @(negedge clk);
    codif  = OpDivu;
    rs1    = 32'd1000;
    rs2    = 32'd10;
    Enable = 1'b1;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e.rd    = 32'd100;
      e.start = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rs1 = 32'd7;
    rs2 = 32'd3;
    for (int i = 0; i < 60 && !Done; i++) @(negedge clk);
    #2;
    end_op();

    // Abort on edge 10.
    @(negedge clk);
    codif  = OpDivu;
    rs1    = 32'd999;
    rs2    = 32'd3;
    Enable = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    Enable = 1'b0;
    watch_no_done("abort_no_done", 45);
    check("abort_keeps_result", rd, 32'd100);
    run_op(OpDivu, 32'd50, 32'd5, 32'd10);
    end_op();

    // Non-divide opcode never starts.
    @(negedge clk);
    codif  = OpMul;
    rs1    = 32'd6;
    rs2    = 32'd3;
    Enable = 1'b1;
    watch_no_done("mul_no_done", 60);
    Enable = 1'b0;
    codif  = OpDiv;
    #1;
    check("mul_left_result", rd, 32'd10);

    // Reset on edge 20 of an operation.
    @(negedge clk);
    codif  = OpDiv;
    rs1    = 32'd81;
    rs2    = 32'd9;
    Enable = 1'b1;
    @(posedge clk);
    repeat (18) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    Enable = 1'b0;
    #1;
    check("midreset_rd", rd, 32'd0);
    watch_no_done("midreset_no_done", 45);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset; clock clk.
REQ-003 SHALL have port Enable  input  1  operation request, held high until Done is observed.
REQ-004 SHALL have port rs1  input  32  dividend.
REQ-005 SHALL have port rs2  input  32  divisor.
REQ-006 SHALL have port codif  input  12  operation select {funct7[1:0], funct3, opcode}.
REQ-007 SHALL have port rd  output  32  result; high-impedance when codif is not a divide operation.
REQ-008 SHALL have port Done  output  1  result valid.
REQ-009 SHALL have parameter XLEN, default 32, meaning operand width; the iteration count equals XLEN.

Function
REQ-010 SHALL decode codif as follows: DIV=011000110011, DIVU=011010110011, REM=011100110011, REMU=011110110011; any other value is "not oper".
REQ-011 SHALL drive rd from the result register when codif decodes as oper (combinational decode of the current codif), and 32'hzzzzzzzz otherwise.
REQ-012 SHALL implement FSM states IDLE, LOAD, CALC, FIX and DONE.
REQ-013 IDLE -> LOAD SHALL occur when Enable=1 and codif is oper; otherwise the FSM stays in IDLE.
REQ-014 LOAD SHALL latch codif and the operand magnitudes (absolute value for DIV/REM when the sign bit is set, raw value for DIVU/REMU), latch the quotient and remainder sign flags, clear the partial remainder and iteration counter, then go to CALC.
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle for exactly XLEN cycles, then go to FIX.
REQ-016 FIX SHALL apply sign and special-case correction, write the result register, then go to DONE.
REQ-017 DONE SHALL hold Done=1 while Enable=1; on Enable=0 it SHALL go to IDLE, with Done=0 from the next cycle.
REQ-018 Latency SHALL be fixed: Done rises on the 35th rising edge after the edge that samples Enable=1 in IDLE, independent of operand values.
REQ-019 In any state other than IDLE or DONE, Enable=0 SHALL abort to IDLE; the result register is unchanged and Done is not asserted.
REQ-020 Signed results: quotient is negative iff the operand signs differ; remainder takes the sign of the dividend; quotient rounds toward zero.
REQ-021 Divide by zero: quotient SHALL be 32'hFFFFFFFF (all opcodes) and remainder SHALL be rs1 unmodified.
REQ-022 Signed overflow (DIV/REM with rs1=32'h80000000, rs2=32'hFFFFFFFF): quotient SHALL be 32'h80000000 and remainder SHALL be 0.
REQ-023 The result register SHALL hold its value until the next FIX; rs1, rs2 and codif changes after LOAD SHALL NOT affect the operation in progress.
REQ-024 Done SHALL be asserted only in DONE.

Reset
REQ-025 With reset=0 at a clock edge, the FSM SHALL go to IDLE and the counter, partial remainder and result register SHALL be cleared to 0; Done=0.
REQ-026 Reset asserted mid-operation SHALL abandon the operation with the same values as REQ-025; rd tri-state behaviour SHALL still follow codif.

Verification
REQ-027 DIVU, rs1=100, rs2=7, Enable held high -> Done=1 on edge 35 and rd=32'h0000000E; switching codif to REMU while in DONE -> rd shows the stored register, 32'h0000000E (result not recomputed).
REQ-028 DIV, rs1=32'hFFFFFFF9 (-7), rs2=2 -> rd=32'hFFFFFFFD; REM with the same operands -> rd=32'hFFFFFFFF.
REQ-029 DIV, rs1=32'h12345678, rs2=0 -> rd=32'hFFFFFFFF; REMU with the same operands -> rd=32'h12345678.
REQ-030 DIV, rs1=32'h80000000, rs2=32'hFFFFFFFF -> rd=32'h80000000; REM with the same operands -> rd=0.
REQ-031 Enable dropped on edge 10 of a DIVU operation -> Done stays 0; a following DIVU 50/5 -> Done on edge 35, rd=10.
REQ-032 codif=12'b010000110011 (MUL) with Enable=1 -> rd=Z and Done=0 indefinitely; reset=0 on edge 20 of an operation -> Done=0 and the result register reads 0.
